// File: rtl/uart_instr_loader.sv
// UART instruction loader: frames RX bytes into 16-bit words, validates opcode and
// checksum, writes IMEM and holds the CPU stalled until a good image is loaded.
module uart_instr_loader #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [15:0]       o_imem_wdata,
   output logic              o_cpu_hold,
   output logic              o_done,
   output logic              o_err,
   output logic [2:0]        o_err_code
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned CW    = ((ADDR_W > 8) ? ADDR_W : 8) + 1;

   localparam logic [2:0] ERR_COUNT   = 3'd1;
   localparam logic [2:0] ERR_OPCODE  = 3'd2;
   localparam logic [2:0] ERR_TIMEOUT = 3'd3;
   localparam logic [2:0] ERR_CHKSUM  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_HI, S_LO, S_CHECK, S_DONE, S_ERROR
   } state_t;

   state_t            state, state_d;
   logic [7:0]        n_q, n_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        chk_q, chk_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [15:0]       wdata_d;
   logic [2:0]        err_code_d;
   logic              busy;
   logic              timeout;

   // State and datapath registers; status outputs follow the next state
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= S_IDLE;
         n_q          <= '0;
         idx_q        <= '0;
         hi_q         <= '0;
         chk_q        <= '0;
         tmr_q        <= '0;
         o_imem_we    <= 1'b0;
         o_imem_addr  <= '0;
         o_imem_wdata <= '0;
         o_cpu_hold   <= 1'b1;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_err_code   <= '0;
      end else begin
         state        <= state_d;
         n_q          <= n_d;
         idx_q        <= idx_d;
         hi_q         <= hi_d;
         chk_q        <= chk_d;
         tmr_q        <= tmr_d;
         o_imem_we    <= we_d;
         o_imem_addr  <= addr_d;
         o_imem_wdata <= wdata_d;
         o_cpu_hold   <= (state_d != S_DONE);
         o_done       <= (state_d == S_DONE);
         o_err        <= (state_d == S_ERROR);
         o_err_code   <= err_code_d;
      end
   end

   assign busy    = (state == S_COUNT) || (state == S_HI) || (state == S_LO) || (state == S_CHECK);
   assign timeout = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

   // Next-state and datapath updates
   always_comb begin
      state_d    = state;
      n_d        = n_q;
      idx_d      = idx_q;
      hi_d       = hi_q;
      chk_d      = chk_q;
      tmr_d      = '0;
      we_d       = 1'b0;
      addr_d     = o_imem_addr;
      wdata_d    = o_imem_wdata;
      err_code_d = o_err_code;

      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (i_rx_valid && i_rx_data == HDR_BYTE) begin
               state_d    = S_COUNT;
               err_code_d = '0;
            end
         end
         S_COUNT: begin
            if (i_rx_valid) begin
               if (i_rx_data == 8'd0 || 32'(i_rx_data) > DEPTH) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_COUNT;
               end else begin
                  n_d     = i_rx_data;
                  idx_d   = '0;
                  chk_d   = '0;
                  state_d = S_HI;
               end
            end
         end
         S_HI: begin
            // Opcode field check against the legal set 4'b0000..4'b1010
            if (i_rx_valid) begin
               if (i_rx_data[7:4] > 4'b1010) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_OPCODE;
               end else begin
                  hi_d    = i_rx_data;
                  state_d = S_LO;
               end
            end
         end
         S_LO: begin
            if (i_rx_valid) begin
               chk_d   = chk_q ^ hi_q ^ i_rx_data;
               we_d    = 1'b1;
               addr_d  = idx_q;
               wdata_d = {hi_q, i_rx_data};
               if (CW'(idx_q) + CW'(1) == CW'(n_q)) begin
                  state_d = S_CHECK;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = S_HI;
               end
            end
         end
         S_CHECK: begin
            if (i_rx_valid) begin
               if (i_rx_data == chk_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_CHKSUM;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Inter-byte watchdog inside a frame; a consumed byte restarts it
      if (busy && !i_rx_valid) begin
         if (timeout) begin
            state_d    = S_ERROR;
            err_code_d = ERR_TIMEOUT;
         end else begin
            tmr_d = tmr_q + TMR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Scoreboard bench for uart_instr_loader: expected IMEM writes are queued by the
// stimulus and popped by a monitor; status levels are checked after each byte.
module tb_uart_instr_loader;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned TMO    = 64;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;

   logic              clk;
   logic              rst;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [2:0]        err_code;

   int  vectors;
   int  miscompares;
   wr_t exp_q[$];
   wr_t mon_e;

   uart_instr_loader #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .HDR_BYTE(8'hA5)
   ) dut (
      .i_clk(clk), .i_reset(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
      .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
      .o_cpu_hold(cpu_hold), .o_done(done), .o_err(err), .o_err_code(err_code)
   );

   always #5 clk = ~clk;

   // Write monitor: every pulse must match the head of the expected queue
   always @(negedge clk) begin
      if (imem_we) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write got addr=%0h data=%04h, none expected", imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
               miscompares++;
               $display("FAIL imem_write got addr=%0h data=%04h, expected addr=%0h data=%04h",
                        imem_addr, imem_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic status(input string name, input logic h, input logic d, input logic e,
                         input logic [2:0] c);
      check({name, "_hold"}, 16'(cpu_hold), 16'(h));
      check({name, "_done"}, 16'(done), 16'(d));
      check({name, "_err"}, 16'(err), 16'(e));
      check({name, "_code"}, 16'(err_code), 16'(c));
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input int a, input logic [15:0] d);
      wr_t w;
      w.addr = ADDR_W'(a);
      w.data = d;
      exp_q.push_back(w);
   endtask

   initial begin
      logic [7:0] hi;
      logic [7:0] lo;
      logic [7:0] chk;
      clk = 1'b0; rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
      vectors = 0; miscompares = 0;
      idle(2);
      status("reset", 1'b1, 1'b0, 1'b0, 3'd0);
      check("reset_we", 16'(imem_we), 16'd0);
      rst = 1'b0;
      idle(1);

      // Good two-word frame
      expect_wr(0, 16'h0010); expect_wr(1, 16'h2005);
      send(8'hA5); send(8'h02); send(8'h00); send(8'h10); send(8'h20); send(8'h05);
      status("t1_pre_chk", 1'b1, 1'b0, 1'b0, 3'd0);
      send(8'h35);
      status("t1_done", 1'b0, 1'b1, 1'b0, 3'd0);

      // Illegal opcode 4'b1011
      send(8'hA5);
      status("t2_hdr", 1'b1, 1'b0, 1'b0, 3'd0);
      send(8'h01); send(8'hB0);
      status("t2_opc", 1'b1, 1'b0, 1'b1, 3'd2);
      send(8'h00);
      status("t2_ignored", 1'b1, 1'b0, 1'b1, 3'd2);

      // Bad checksum after a written word
      expect_wr(0, 16'h1234);
      send(8'hA5); send(8'h01); send(8'h12); send(8'h34); send(8'h00);
      status("t3_chk", 1'b1, 1'b0, 1'b1, 3'd4);

      // Count zero, count above DEPTH, then recovery
      send(8'hA5); send(8'h00);
      status("t4_n0", 1'b1, 1'b0, 1'b1, 3'd1);
      send(8'hA5);
      status("t4_hdr_clr", 1'b1, 1'b0, 1'b0, 3'd0);
      send(8'd17);
      status("t4_n17", 1'b1, 1'b0, 1'b1, 3'd1);
      expect_wr(0, 16'h1234);
      send(8'hA5); send(8'h01); send(8'h12); send(8'h34); send(8'h26);
      status("t4_done", 1'b0, 1'b1, 1'b0, 3'd0);

      // Header byte as data, opcode 4'b1010 legal
      expect_wr(0, 16'hA5A5);
      send(8'hA5); send(8'h01); send(8'hA5); send(8'hA5); send(8'h00);
      status("t4b_done", 1'b0, 1'b1, 1'b0, 3'd0);

      // Inter-byte timeout
      expect_wr(0, 16'h0010);
      send(8'hA5); send(8'h02); send(8'h00); send(8'h10);
      idle(TMO - 1);
      status("t5_before", 1'b1, 1'b0, 1'b0, 3'd0);
      idle(1);
      status("t5_timeout", 1'b1, 1'b0, 1'b1, 3'd3);

      // Full-depth frame, one byte per cycle
      chk = '0;
      send(8'hA5); send(8'(DEPTH));
      for (int i = 0; i < int'(DEPTH); i++) begin
         hi  = 8'((i % 11) << 4) | 8'(i);
         lo  = 8'(i * 7 + 3);
         chk = chk ^ hi ^ lo;
         expect_wr(i, {hi, lo});
         send(hi); send(lo);
      end
      send(chk);
      status("t6_done", 1'b0, 1'b1, 1'b0, 3'd0);

      // Reset mid-frame, with a LO byte arriving in the reset cycle
      send(8'hA5);
      status("t6_rehold", 1'b1, 1'b0, 1'b0, 3'd0);
      send(8'(DEPTH));
      for (int i = 0; i < 5; i++) begin
         expect_wr(i, {8'(i), 8'h11});
         send(8'(i)); send(8'h11);
      end
      send(8'h07);
      rst = 1'b1;
      send(8'h22);
      rst = 1'b0;
      status("t6_reset", 1'b1, 1'b0, 1'b0, 3'd0);
      check("t6_reset_we", 16'(imem_we), 16'd0);
      send(8'h12); send(8'h34);
      idle(4);
      status("t6_idle", 1'b1, 1'b0, 1'b0, 3'd0);
      check("pending_writes", 16'(exp_q.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
